// File: rtl/wb_responder_regbank_pkg.sv
// rtl/wb_responder_regbank_pkg.sv - shared offsets, FSM encoding and default ID for the Wishbone register bank
package wb_responder_pkg;

    localparam int REG_ID      = 0;
    localparam int REG_CTRL    = 1;
    localparam int REG_TXN     = 2;
    localparam int REG_SCRATCH = 3;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h7704_0B01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_responder_regbank_if.sv
// rtl/wb_responder_regbank_if.sv - Wishbone classic signal bundle with master/slave views
interface wb_responder_regbank_if;

    logic        wb_CYC;
    logic        wb_STB;
    logic        wb_WE;
    logic [13:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [3:0]  wb_SEL;
    logic [31:0] wb_DAT_MISO;
    logic        wb_ACK;

    modport master (
        output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
        input  wb_DAT_MISO, wb_ACK
    );

    modport slave (
        input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_DAT_MOSI, wb_SEL,
        output wb_DAT_MISO, wb_ACK
    );

endinterface

// File: rtl/wb_responder_regbank_byte_merge.sv
// rtl/wb_responder_regbank_byte_merge.sv - combinational byte-lane merge of a new word over an old word
module wb_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) begin
                merged[8*n +: 8] = new_word[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_responder_regbank.sv
// rtl/wb_responder_regbank.sv - Wishbone classic responder with ID/CTRL/TXN/scratch register bank
// Optional WB_RESPONDER_PROG_WAIT_EN: wait count taken from CTRL[3:0] instead of WAIT_STATES.
module wb_responder_regbank
    import wb_responder_pkg::*;
#(
    parameter logic [13:0] BASE_ADR    = 14'h0000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    wb_responder_regbank_if.slave   wb,
    output logic [31:0]             ctrl_out
);

    localparam int          IDX_W   = $clog2(NUM_REGS);
    localparam logic [13:0] NREGS_W = 14'(NUM_REGS);
`ifdef WB_RESPONDER_PROG_WAIT_EN
    localparam logic [31:0] CTRL_RST = {28'h0, 4'(WAIT_STATES)};
`else
    localparam logic [31:0] CTRL_RST = 32'h0;
`endif

    wb_state_t        state, next_state;
    logic [3:0]       wait_cnt;
    logic [3:0]       wait_val;
    logic [13:0]      lat_adr;
    logic             lat_we;
    logic [3:0]       lat_sel;
    logic [31:0]      lat_dat;
    logic [31:0]      regs [NUM_REGS];
    logic [31:0]      txn_cnt;
    logic [31:0]      dat_miso;
    logic             req;

    assign req      = wb.wb_CYC & wb.wb_STB;
    assign ctrl_out = regs[REG_CTRL];

`ifdef WB_RESPONDER_PROG_WAIT_EN
    assign wait_val = regs[REG_CTRL][3:0];
`else
    assign wait_val = 4'(WAIT_STATES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = (wait_val != 4'd0) ? WAIT : ACK;
            WAIT: begin
                if (!req) begin
                    next_state = IDLE;
                end else if (wait_cnt == 4'd1) begin
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wb.wb_ACK      = (state == ACK);
        wb.wb_DAT_MISO = dat_miso;
    end

    // A zero-wait request goes straight to ACK, so the read mux must see the live bus address.
    logic [13:0]      rd_adr, rd_off;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;

    assign rd_adr = (state == IDLE) ? wb.wb_ADR : lat_adr;
    assign rd_off = rd_adr - BASE_ADR;
    assign rd_idx = rd_off[IDX_W-1:0];

    always_comb begin
        rd_word = 32'h0;
        if (rd_off < NREGS_W) begin
            if (rd_idx == IDX_W'(REG_ID)) begin
                rd_word = ID_VALUE;
            end else if (rd_idx == IDX_W'(REG_TXN)) begin
                rd_word = txn_cnt;
            end else begin
                rd_word = regs[rd_idx];
            end
        end
    end

    logic [13:0]      wr_off;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;
    logic [31:0]      wr_word;

    assign wr_off = lat_adr - BASE_ADR;
    assign wr_idx = wr_off[IDX_W-1:0];
    assign wr_en  = (state == ACK) && lat_we && (wr_off < NREGS_W)
                 && (wr_idx != IDX_W'(REG_ID)) && (wr_idx != IDX_W'(REG_TXN));

    wb_byte_merge u_merge (
        .old_word (regs[wr_idx]),
        .new_word (lat_dat),
        .sel      (lat_sel),
        .merged   (wr_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            lat_adr  <= 14'h0;
            lat_we   <= 1'b0;
            lat_sel  <= 4'h0;
            lat_dat  <= 32'h0;
            txn_cnt  <= 32'h0;
            dat_miso <= 32'h0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == REG_CTRL) ? CTRL_RST : 32'h0;
            end
        end else begin
            if (state == IDLE && req) begin
                lat_adr  <= wb.wb_ADR;
                lat_we   <= wb.wb_WE;
                lat_sel  <= wb.wb_SEL;
                lat_dat  <= wb.wb_DAT_MOSI;
                wait_cnt <= wait_val;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (wr_en) begin
                regs[wr_idx] <= wr_word;
            end
            if (state == ACK) begin
                txn_cnt <= txn_cnt + 32'd1;
            end
            dat_miso <= (next_state == ACK) ? rd_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_wb_responder_regbank.sv
// tb/tb_wb_responder_regbank.sv - scoreboard bench: random Wishbone traffic against a register-map model
module tb_wb_responder_regbank;

    localparam logic [13:0] BASE   = 14'h0000;
    localparam int          NREGS  = 16;
    localparam int          WAITS  = 1;
    localparam logic [31:0] ID_EXP = 32'h7704_0B01;
`ifdef WB_RESPONDER_PROG_WAIT_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl_out;

    wb_responder_regbank_if bus ();

    wb_responder_regbank #(
        .BASE_ADR    (BASE),
        .NUM_REGS    (NREGS),
        .WAIT_STATES (WAITS),
        .ID_VALUE    (ID_EXP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (bus),
        .ctrl_out (ctrl_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mregs [NREGS];
    logic [31:0] mtxn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_off(input logic [13:0] adr);
        logic [13:0] d;
        d = adr - BASE;
        return int'(d);
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] adr);
        int o;
        o = m_off(adr);
        if (o >= NREGS) return 32'h0;
        if (o == 0) return ID_EXP;
        if (o == 2) return mtxn;
        return mregs[o];
    endfunction

    task automatic m_write(input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int o;
        o = m_off(adr);
        if (o < NREGS && o != 0 && o != 2) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mregs[o][8*b +: 8] = dat[8*b +: 8];
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;
        mregs[1] = PROG ? 32'(WAITS) : 32'h0;
        mtxn     = 32'h0;
    endtask

    function automatic int m_wait();
        return PROG ? int'(mregs[1][3:0]) : WAITS;
    endfunction

    task automatic drive(input bit we, input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.wb_CYC      = 1'b1;
        bus.wb_STB      = 1'b1;
        bus.wb_WE       = we;
        bus.wb_ADR      = adr;
        bus.wb_DAT_MOSI = dat;
        bus.wb_SEL      = sel;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        @(negedge clk);
        while (!bus.wb_ACK && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic txn(input bit we, input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int   w, n;
        exp_t e;
        w = m_wait();
        @(negedge clk);
        drive(we, adr, dat, sel);
        e.rd   = !we;
        e.data = m_read(adr);
        sb.push_back(e);
        if (we) m_write(adr, dat, sel);
        mtxn = mtxn + 32'd1;
        @(posedge clk);
        wait_ack(n);
        check("ack_latency", 32'(n), 32'(w));
        @(posedge clk);
        #1 check("ctrl_out", ctrl_out, mregs[1]);
    endtask

    task automatic idle(input int k, input bit cyc);
        @(negedge clk);
        bus.wb_CYC = cyc;
        bus.wb_STB = 1'b0;
        repeat (k) @(posedge clk);
    endtask

    task automatic abort_txn(input bit we, input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int w, k;
        w = m_wait();
        if (w == 0) return;
        k = $urandom_range(w - 1, 0);
        @(negedge clk);
        drive(we, adr, dat, sel);
        @(posedge clk);
        repeat (k) @(posedge clk);
        @(negedge clk);
        if ($urandom_range(1, 0) == 1) bus.wb_CYC = 1'b0;
        bus.wb_STB = 1'b0;
        repeat (w + 2) begin
            @(posedge clk);
            #1 check("abort_no_ack", 32'(bus.wb_ACK), 32'h0);
        end
    endtask

    task automatic reset_mid(input bit in_ack);
        int   n;
        bit   eff;
        exp_t e;
        eff = in_ack || (m_wait() == 0);
        @(negedge clk);
        drive(1'b1, BASE + 14'd3, 32'hDEAD_BEEF, 4'hF);
        if (eff) begin
            e.rd   = 1'b0;
            e.data = 32'h0;
            sb.push_back(e);
        end
        @(posedge clk);
        if (eff) begin
            wait_ack(n);
            #1 rst = 1'b1;
        end else begin
            #2 rst = 1'b1;
        end
        m_reset();
        #1;
        check("rst_ack", 32'(bus.wb_ACK), 32'h0);
        check("rst_miso", bus.wb_DAT_MISO, 32'h0);
        check("rst_ctrl", ctrl_out, mregs[1]);
        @(negedge clk);
        bus.wb_CYC = 1'b0;
        bus.wb_STB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: pops one expectation per ACK, data checked on reads only.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_ACK) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ack: got ACK=1 expected no ACK at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.rd) check("read_data", bus.wb_DAT_MISO, mon_e.data);
                end
            end else begin
                check("miso_idle", bus.wb_DAT_MISO, 32'h0);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] a;
        logic [31:0] d;
        bus.wb_CYC      = 1'b0;
        bus.wb_STB      = 1'b0;
        bus.wb_WE       = 1'b0;
        bus.wb_ADR      = 14'h0;
        bus.wb_DAT_MOSI = 32'h0;
        bus.wb_SEL      = 4'h0;
        rst = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(bus.wb_ACK), 32'h0);
        check("reset_miso", bus.wb_DAT_MISO, 32'h0);
        check("reset_ctrl", ctrl_out, mregs[1]);
        @(negedge clk);
        rst = 1'b0;

        txn(1'b0, BASE, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd2, 32'h0, 4'hF);

        txn(1'b1, BASE + 14'd3, 32'hA5A5_5A5A, 4'b1111);
        txn(1'b1, BASE + 14'd3, 32'h0000_00FF, 4'b0001);
        txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);

        txn(1'b1, BASE, 32'h1234_5678, 4'hF);
        txn(1'b1, BASE + 14'd2, 32'hFFFF_FFFF, 4'hF);
        txn(1'b0, BASE, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd2, 32'h0, 4'hF);

        txn(1'b0, BASE + 14'(NREGS), 32'h0, 4'hF);
        txn(1'b1, BASE + 14'(NREGS), 32'hCAFE_F00D, 4'hF);
        txn(1'b1, BASE + 14'd3, 32'h0000_0000, 4'b0000);
        for (int i = 0; i < NREGS; i++) txn(1'b0, BASE + 14'(i), 32'h0, 4'hF);

        abort_txn(1'b1, BASE + 14'd3, 32'h0BAD_0BAD, 4'hF);
        txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd2, 32'h0, 4'hF);

        if (PROG) begin
            txn(1'b1, BASE + 14'd1, 32'h0000_0004, 4'hF);
            txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);
            txn(1'b1, BASE + 14'd1, 32'h0000_0000, 4'hF);
            txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);
            txn(1'b1, BASE + 14'd1, 32'h0000_0003, 4'hF);
            abort_txn(1'b1, BASE + 14'd4, 32'h5555_AAAA, 4'hF);
            txn(1'b0, BASE + 14'd4, 32'h0, 4'hF);
        end

        reset_mid(1'b0);
        txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd1, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd2, 32'h0, 4'hF);
        reset_mid(1'b1);
        txn(1'b0, BASE + 14'd3, 32'h0, 4'hF);
        txn(1'b0, BASE + 14'd2, 32'h0, 4'hF);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1), 1'($urandom_range(1, 0)));
            if ($urandom_range(4, 0) != 0) a = BASE + 14'($urandom_range(NREGS - 1, 0));
            else a = 14'($urandom_range(16383, 0));
            d = $urandom;
            if ($urandom_range(9, 0) == 0) abort_txn(1'($urandom_range(1, 0)), a, d, 4'($urandom_range(15, 0)));
            else txn(1'($urandom_range(1, 0)), a, d, 4'($urandom_range(15, 0)));
        end

        idle(3, 1'b0);
        check("queue_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
